// File: rtl/galois_pkg.sv
// rtl/galois_pkg.sv - shared opcodes, BN254 modulus and helpers for the GF(p) add/sub pipe
package galois_pkg;

   localparam logic [1:0] OP_ADD      = 2'b00;
   localparam logic [1:0] OP_SUB      = 2'b01;
   localparam logic [1:0] OP_ACC      = 2'b10;
   localparam logic [1:0] OP_ACC_LOAD = 2'b11;

   localparam logic [253:0] BN254_R =
      254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

   // Both accumulator opcodes share the high bit.
   function automatic logic is_acc_op(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/galois_reduce.sv
// rtl/galois_reduce.sv - single conditional correction of an (N_BITS+1)-bit raw sum/difference into [0, p)
module galois_reduce
   import galois_pkg::*;
#(
   parameter int                N_BITS        = 254,
   parameter logic [N_BITS-1:0] PRIME_MODULUS = BN254_R
) (
   input  logic [N_BITS:0]   raw,
   input  logic              is_sub,
   output logic [N_BITS-1:0] reduced
);

   logic [N_BITS:0]   p_ext;
   logic [N_BITS:0]   minus_p;
   logic [N_BITS-1:0] plus_p;

   assign p_ext   = {1'b0, PRIME_MODULUS};
   assign minus_p = raw - p_ext;
   // A borrowed difference wraps modulo 2^N_BITS once p is added back.
   assign plus_p  = raw[N_BITS-1:0] + PRIME_MODULUS;

   always_comb begin
      reduced = raw[N_BITS-1:0];
      if (is_sub) begin
         if (raw[N_BITS]) reduced = plus_p;
      end else if (raw >= p_ext) begin
         reduced = minus_p[N_BITS-1:0];
      end
   end

endmodule

// File: rtl/galois_addsub_pipe.sv
// rtl/galois_addsub_pipe.sv - 2-stage GF(p) add/sub/accumulate unit with valid/ready on both sides
module galois_addsub_pipe
   import galois_pkg::*;
#(
   parameter int                N_BITS        = 254,
   parameter logic [N_BITS-1:0] PRIME_MODULUS = BN254_R,
   parameter int                TAG_BITS      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          in_op,
   input  logic [N_BITS-1:0]   in_num1,
   input  logic [N_BITS-1:0]   in_num2,
   input  logic [TAG_BITS-1:0] in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N_BITS-1:0]   out_result,
   output logic [TAG_BITS-1:0] out_tag,
   output logic                out_err,
   output logic [N_BITS-1:0]   acc_value
);

   logic                s1_valid;
   logic [1:0]          s1_op;
   logic [TAG_BITS-1:0] s1_tag;
   logic                s1_err;
   logic [N_BITS:0]     s1_raw;
   logic [N_BITS-1:0]   acc;

   logic                adv2;
   logic                s1_adv;
   logic                accept;
   logic [N_BITS:0]     a_ext;
   logic [N_BITS:0]     b_ext;
   logic [N_BITS:0]     raw_next;
   logic                err_next;
   logic [N_BITS-1:0]   reduced;
   logic [N_BITS-1:0]   result;

   assign adv2     = !out_valid || out_ready;
   assign s1_adv   = s1_valid && adv2;
   // An accumulator op in s1 blocks intake until its acc write lands.
   assign in_ready = (!s1_valid || adv2) && !(s1_valid && is_acc_op(s1_op));
   assign accept   = in_valid && in_ready;

   assign acc_value = acc;

   always_comb begin
      a_ext    = {1'b0, in_num1};
      b_ext    = (in_op == OP_ACC) ? {1'b0, acc} : {1'b0, in_num2};
      raw_next = a_ext;
      case (in_op)
         OP_ADD, OP_ACC: raw_next = a_ext + b_ext;
         OP_SUB:         raw_next = a_ext - b_ext;
         default:        raw_next = a_ext;
      endcase
      err_next = (in_num1 >= PRIME_MODULUS) ||
                 ((in_num2 >= PRIME_MODULUS) && !is_acc_op(in_op));
   end

   galois_reduce #(
      .N_BITS        (N_BITS),
      .PRIME_MODULUS (PRIME_MODULUS)
   ) u_reduce (
      .raw     (s1_raw),
      .is_sub  (s1_op == OP_SUB),
      .reduced (reduced)
   );

   assign result = (s1_op == OP_ACC_LOAD) ? s1_raw[N_BITS-1:0] : reduced;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_op      <= OP_ADD;
         s1_tag     <= '0;
         s1_err     <= 1'b0;
         s1_raw     <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
         out_err    <= 1'b0;
         acc        <= '0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_tag   <= in_tag;
            s1_err   <= err_next;
            s1_raw   <= raw_next;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end

         if (s1_adv) begin
            out_valid  <= 1'b1;
            out_result <= result;
            out_tag    <= s1_tag;
            out_err    <= s1_err;
            if (is_acc_op(s1_op)) acc <= result;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/galois_addsub_pipe.md
Name: galois_addsub_pipe

Overview:
- Pipelined modular add/subtract/accumulate unit over GF(p), parametrised in width, modulus and tag width.
- Successor of the combinational field adder. Adds SUB and running-accumulator modes, a 2-stage pipeline, and valid/ready handshakes on both sides.
- Sits between the MiMC round controller and the field multiplier. Carries a tag through so that out-of-order consumers can match results.

Parameters:
- N_BITS, 254, field element width.
- PRIME_MODULUS, 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, field prime p (N_BITS wide).
- TAG_BITS, 8, width of the opaque sideband tag.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts the operation this cycle.
- in_op  in  2  operation code: 00 ADD, 01 SUB, 10 ACC, 11 ACC_LOAD.
- in_num1  in  N_BITS  operand a.
- in_num2  in  N_BITS  operand b; ignored for ACC and ACC_LOAD.
- in_tag  in  TAG_BITS  sideband, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_result  out  N_BITS  reduced result in [0, p).
- out_tag  out  TAG_BITS  tag of this result.
- out_err  out  1  a used operand was >= p.
- acc_value  out  N_BITS  current accumulator contents.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset state: s1_valid=0, out_valid=0, out_result=0, out_tag=0, out_err=0, acc=0. Reset mid-operation drops all in-flight operations with no output, and acc returns to 0.
- Transfers: an input transfers when in_valid && in_ready. An output transfers when out_valid && out_ready.
- Stage 1 (register on accept): op, tag, err flag, and raw = a+b or a-b as (N_BITS+1)-bit two's complement.
  - ADD: a+b.
  - SUB: a-b.
  - ACC: a+acc.
  - ACC_LOAD: raw = a.
- Stage 2 (correction between s1 and output registers; see the sub-module under Decomposition):
  - ADD/ACC: result = raw >= p ? raw-p : raw.
  - SUB: result = raw[N_BITS] ? raw+p : raw, taken modulo 2^N_BITS.
  - ACC_LOAD: result = raw.
  - Result is always < p when the operands are < p.
- Accumulator update: acc is written with the corrected result in the same cycle that an ACC or ACC_LOAD moves from s1 to the output registers.
- Latency: out_valid rises exactly 2 cycles after acceptance when there is no backpressure.
- Flow control:
  - adv2 = !out_valid || out_ready.
  - s1 moves to the output registers when s1_valid && adv2.
  - in_ready = (!s1_valid || adv2) && !(s1_valid && s1_op is ACC or ACC_LOAD).
- Hazard rule: while an accumulator op sits in s1, no new input is accepted. ADD/SUB sustain 1 per cycle. Back-to-back ACC ops sustain 1 per 2 cycles, and every ACC sees the acc written by the previous one.
- in_ready does not depend on in_valid or in_op (no combinational path from inputs to in_ready).
- Output hold: out_* hold stable while out_valid && !out_ready. Full backpressure fills s1 and then drops in_ready. There is no data loss and no duplication.
- Error flag: out_err = (a >= p) || (b >= p && op in {ADD, SUB}). The result is still computed by the formulas above. The unit does not stall on error.
- Width rules:
  - ADD and ACC need the full N_BITS+1 sum; the carry must not be truncated before the compare.
  - SUB detects a borrow via bit N_BITS.
- Simultaneous events:
  - Output transfer and s1 advance in the same cycle is legal, giving full throughput.
  - Acceptance into s1 in the same cycle that s1 empties into s2 is legal.
- acc_value: driven directly from the acc register.

Decomposition:
- Shared package galois_pkg:
  - opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_ACC=2'b10, OP_ACC_LOAD=2'b11.
  - BN254_R modulus constant.
  - an is_acc_op helper function.
- One combinational sub-module galois_reduce (parameters N_BITS, PRIME_MODULUS): input raw[N_BITS:0] and is_sub, output reduced[N_BITS-1:0]. It is instantiated once between s1 and the output registers.

Test Plan:
- ADD a=p-1, b=2, tag=0x11, out_ready=1 -> out_result=1, out_tag=0x11, out_err=0, out_valid exactly 2 cycles after accept.
- SUB a=3, b=5 -> out_result=p-2. SUB a=5, b=5 -> 0. ADD a=0, b=0 -> 0.
- ACC_LOAD a=5, then ACC a=p-1, then ACC a=10, offered back-to-back -> results 5, 4, 14 and acc_value=14. in_ready is low in the cycle after each accumulator accept. A 3-op sequence takes 5 accepting cycles.
- Stream 6 ADDs (a=i, b=1) while holding out_ready=0 for 4 cycles -> in_ready falls after 2 accepts. After release, results 1..6 arrive in order with matching tags, none lost or duplicated.
- ADD a=p, b=0 -> out_err=1. ACC_LOAD a=0, b=p -> out_err=0.
- Assert rst for 1 cycle with 2 ops in flight and acc=7 -> the next cycle shows out_valid=0, acc_value=0, in_ready=1, and a subsequent ADD 1+1 returns 2.
